tanh_arbiter: RTL

TANH_ARBITER -- requirements
Module: tanh_arbiter

---
 rtl/tanh_arbiter_if.sv | 27 ++
 rtl/tanh_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/tanh_arbiter_if.sv
// Bundle between the tanh arbiter, its requesters and the shared tanh unit.
// The arbiter takes the slave view; the requester/tanh-unit side takes the master view.
interface tanh_arbiter_if #(
  parameter int W     = 18,
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_operand;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       tanh_operand;
  logic [W-1:0]       tanh_result;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_data;
  logic               busy;

  modport slave (
    input  req_valid, req_operand, tanh_result,
    output req_ready, tanh_operand, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_operand, tanh_result,
    input  req_ready, tanh_operand, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/tanh_arbiter.sv
// Round-robin arbiter sharing one free-running TANH_LAT-phase tanh unit among N_REQ requesters.
// Accepts and result sampling happen only on the last phase, so result k and operand k+1 share an edge.
module tanh_arbiter #(
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int N_REQ    = 4,
  parameter int TANH_LAT = 6
) (
  input  logic          clock,
  input  logic          reset,
  tanh_arbiter_if.slave arb
);
  localparam int W   = QN + QM + 1;
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(TANH_LAT);
  localparam logic [PW-1:0] LAST_PHASE = PW'(TANH_LAT - 1);

  logic [PW-1:0]  r_phase;
  logic [IDW-1:0] r_ptr;
  logic           r_active;
  logic [W-1:0]   r_op;
  logic [IDW-1:0] r_cur_id;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_data;
  logic [IDW-1:0] r_rsp_id;

  logic             w_slot;
  logic             w_found;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_gnt_id;
  logic [W-1:0]     w_gnt_op;
  logic [N_REQ-1:0] w_ready;

  assign w_slot = (r_phase == LAST_PHASE) && !reset;

  // NOTE: every variable gets a default before the loop; otherwise an unassigned path infers a latch.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // N_REQ is a power of two, so the IDW-bit sum wraps round-robin for free.
      w_idx = r_ptr + IDW'(k);
      if (!w_found && arb.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  assign w_gnt_op = arb.req_operand[w_gnt_id*W +: W];
  assign w_ready  = (w_slot && w_found) ? (N_REQ'(1) << w_gnt_id) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase     <= '0;
      r_ptr       <= '0;
      r_active    <= 1'b0;
      r_op        <= '0;
      r_cur_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      r_phase     <= (r_phase == LAST_PHASE) ? '0 : r_phase + 1'b1;
      r_rsp_valid <= 1'b0;
      if (w_slot) begin
        if (r_active) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= arb.tanh_result;
          r_rsp_id    <= r_cur_id;
        end
        if (w_found) begin
          r_op     <= w_gnt_op;
          r_cur_id <= w_gnt_id;
          r_active <= 1'b1;
          r_ptr    <= w_gnt_id + 1'b1;
        end else begin
          r_active <= 1'b0;
        end
      end
    end
  end

  assign arb.req_ready    = w_ready;
  assign arb.tanh_operand = r_active ? r_op : '0;
  assign arb.rsp_valid    = r_rsp_valid;
  assign arb.rsp_id       = r_rsp_id;
  assign arb.rsp_data     = r_rsp_data;
  assign arb.busy         = r_active;
endmodule
